psm_host: RTL
=============

// Module: psm_host
// PURPOSE
//  Initiator/checker on the Start_N/Din1/Din2 -> Ready/Op1/Op2/Op3/Dout interface of the PSM.
//  Accepts a one-word request (A,B), drives a clean active-low start pulse with stable operands,
//  then follows the PSM's three timed phases, captures Dout per phase and checks phase lengths and values.
//  Sits between the system controller and the PSM; one transaction in flight at a time.
// PARAMETERS
//  TIME_OP1   30_000_000  expected Op1 length, cycles
//  TIME_OP2   10_000_000  expected Op2 length, cycles
//  TIME_OP3   80_000_000  expected Op3 length, cycles
//  START_LEN  2           cycles Start_N held low (>=1)
//  TIMEOUT    16          max cycles from Start_N fall to Op1 rise
//  CNT_W      32          phase counter width (must hold max(TIME_OPx)+1)
// PORTS
//  Clock    in   1  single clock, all logic on posedge
//  Reset    in   1  synchronous, active-high reset
//  Req      in   1  request; accepted when high and Busy low
//  ReqA     in   3  operand A, sampled on accept
//  ReqB     in   3  operand B, sampled on accept
//  Busy     out  1  transaction in flight
//  Done     out  1  one-cycle pulse, transaction finished (Res*/Err valid)
//  Res1     out  3  Dout captured in Op1 (expected A|B)
//  Res2     out  3  Dout captured in Op2 (expected A^B)
//  Res3     out  3  Dout captured in Op3 (expected ~(~A&B))
//  Err      out  1  error flag for last transaction
//  ErrCode  out  3  0 none,1 Op1 timeout,2 phase length,3 Dout mismatch,4 illegal phase/order
//  Start_N  out  1  to PSM, active-low start
//  Din1     out  3  to PSM, operand A
//  Din2     out  3  to PSM, operand B
//  Ready    in   1  from PSM
//  Op1/Op2/Op3 in 1 each, from PSM
//  Dout     in   3  from PSM
// BEHAVIOUR
//  Reset: state IDLE; Start_N=1; Busy=0; Done=0; Din1=Din2=Res1..3=0; Err=0; ErrCode=0. Reset mid-op aborts
//   immediately, no Done; PSM may keep running and next Req waits for Ready (IDLE requires Ready=1 to accept).
//  FSM: IDLE -> START -> WAIT1 -> PH1 -> PH2 -> PH3 -> FIN -> IDLE; any error -> DRAIN -> FIN.
//  IDLE : Req&&Ready -> latch A,B into Din1/Din2, Busy=1, Start_N=0 next cycle, clear Err/ErrCode. Req while Busy ignored.
//  START: Start_N low exactly START_LEN cycles, then high; -> WAIT1. Din1/Din2 held constant until return to IDLE.
//  WAIT1: count cycles from Start_N fall; Op1 seen -> PH1; count reaches TIMEOUT -> ErrCode=1, DRAIN.
//   Op1 rising while still in START is legal (PSM edge-detects): go to PH1 with Start_N forced high.
//  PHn  : counter starts at 1 on first Opn cycle, +1 per cycle Opn stays high; Dout sampled every cycle,
//   Resn = Dout on last Opn cycle. Transition when Opn drops and Op(n+1) (or Ready after Op3) rises same cycle.
//  Length rule: count must equal TIME_OPn exactly; count exceeding TIME_OPn -> error immediately (no wait).
//  One-hot rule: more than one of Ready/Op1/Op2/Op3 high, all low, or wrong successor -> ErrCode=4.
//  Error priority same cycle: 4 > 2 > 3 > 1. First error wins; ErrCode sticky until next accept.
//  DRAIN: wait Ready=1, then FIN. FIN: Done=1 one cycle, Busy=0 same cycle, -> IDLE.
//  Latency: Req accept -> Start_N low 1 cycle; Ready after Op3 -> Done next cycle.
//  Counters saturate at 2^CNT_W-1; no wrap.
// CONFIGURATION
//  PSM_HOST_CHECK_EN defined: Dout value compare (codes 3) and length compare (code 2) compiled in.
//  Undefined: only timeout (1) and one-hot/order (4) checks; Res1..3 still captured; no length compare logic.
// TESTING (sim overrides TIME_OP1=3, TIME_OP2=1, TIME_OP3=8, START_LEN=2, TIMEOUT=16)
//  A=101,B=011 vs PSM model -> Start_N low 2 cycles, Res1=111, Res2=110, Res3=101, Done 1 cycle, Err=0.
//  Req pulsed again during PH2 -> ignored; exactly one Start_N pulse, one Done.
//  Model never raises Op1 -> Err=1, ErrCode=1 16 cycles after Start_N fall, Done after Ready.
//  Model holds Op2 for 2 cycles -> ErrCode=2 on 2nd Op2 cycle (CHECK_EN); without macro Err=0.
//  Model flips Dout bit0 in Op3 with A=000,B=111 -> ErrCode=3 (CHECK_EN); Res3 reflects corrupt value.
//  Reset asserted in PH2 -> next cycle all outputs at reset values; new Req served only after Ready=1.

Source files
------------

// File: rtl/psm_host.sv
// psm_host -- initiator and checker for the PSM Start_N/Din1/Din2 -> Ready/Op1/Op2/Op3/Dout interface.
//
// Accepts one request (A,B) at a time, issues an active-low start pulse of START_LEN cycles with
// stable operands, follows the PSM's three phases, captures Dout per phase and flags protocol errors.
//
// Optional build macro: PSM_HOST_CHECK_EN
//   defined   : phase-length compare (err_code 2) and Dout value compare (err_code 3) are built in.
//   undefined : only Op1 timeout (1) and one-hot/order (4) checks; res1..res3 are still captured.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req, req_a, req_b   request and operands (accepted when req && ready in IDLE)
//   busy, done          transaction in flight / one-cycle completion pulse
//   res1..res3          Dout captured on the last cycle of Op1/Op2/Op3
//   err, err_code       error flag and code (0 none, 1 timeout, 2 length, 3 value, 4 order)
//   start_n, din1, din2 to PSM
//   ready, op1..op3, dout from PSM
module psm_host #(
    parameter int TIME_OP1  = 30_000_000,
    parameter int TIME_OP2  = 10_000_000,
    parameter int TIME_OP3  = 80_000_000,
    parameter int START_LEN = 2,
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [2:0] req_a,
    input  logic [2:0] req_b,
    output logic       busy,
    output logic       done,
    output logic [2:0] res1,
    output logic [2:0] res2,
    output logic [2:0] res3,
    output logic       err,
    output logic [2:0] err_code,
    output logic       start_n,
    output logic [2:0] din1,
    output logic [2:0] din2,
    input  logic       ready,
    input  logic       op1,
    input  logic       op2,
    input  logic       op3,
    input  logic [2:0] dout
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT1, S_PH1, S_PH2, S_PH3, S_DRAIN, S_FIN
    } state_t;

    localparam logic [CNT_W-1:0] START_LEN_C = CNT_W'(START_LEN);
    localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);

    state_t           state_reg;
    logic             busy_reg, done_reg, start_n_reg, err_reg;
    logic [2:0]       din1_reg, din2_reg, res1_reg, res2_reg, res3_reg, err_code_reg;
    logic [CNT_W-1:0] scnt_reg, tcnt_reg, tcnt_next;

    logic [3:0] lines;
    logic       ph_cur, ph_nxt;
    logic       ph_e4, ph_e2, ph_e3, w_e4, w_e3;
    logic [2:0] ph_code, w_code;

    assign lines     = {op3, op2, op1, ready};
    assign tcnt_next = (tcnt_reg == '1) ? tcnt_reg : tcnt_reg + 1'b1;

    // Current-phase line and its only legal successor.
    always_comb begin
        ph_cur = 1'b0;
        ph_nxt = 1'b0;
        case (state_reg)
            S_PH1:   begin ph_cur = op1; ph_nxt = op2;   end
            S_PH2:   begin ph_cur = op2; ph_nxt = op3;   end
            S_PH3:   begin ph_cur = op3; ph_nxt = ready; end
            default: ;
        endcase
    end

    // Inside a phase exactly one line may be high and it must be the current or next one.
    assign ph_e4 = !$onehot(lines) || !(ph_cur || ph_nxt);
    // Before Op1 only Ready may be seen; Op1 must not overlap Ready.
    assign w_e4  = op2 || op3 || (op1 && ready);

`ifdef PSM_HOST_CHECK_EN
    localparam logic [CNT_W-1:0] LEN1_C = CNT_W'(TIME_OP1);
    localparam logic [CNT_W-1:0] LEN2_C = CNT_W'(TIME_OP2);
    localparam logic [CNT_W-1:0] LEN3_C = CNT_W'(TIME_OP3);

    logic [2:0]       exp1, exp2, exp3, cur_exp, nxt_exp;
    logic             nxt_chk;
    logic [CNT_W-1:0] pcnt_reg, pcnt_next, cur_len;

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_exp
        assign exp1[gi] = din1_reg[gi] | din2_reg[gi];
        assign exp2[gi] = din1_reg[gi] ^ din2_reg[gi];
        assign exp3[gi] = ~(~din1_reg[gi] & din2_reg[gi]);
    end

    always_comb begin
        cur_exp = exp1;
        nxt_exp = exp2;
        nxt_chk = 1'b0;
        cur_len = LEN1_C;
        case (state_reg)
            S_PH1:   begin cur_exp = exp1; nxt_exp = exp2; nxt_chk = 1'b1; cur_len = LEN1_C; end
            S_PH2:   begin cur_exp = exp2; nxt_exp = exp3; nxt_chk = 1'b1; cur_len = LEN2_C; end
            S_PH3:   begin cur_exp = exp3; nxt_exp = exp3; nxt_chk = 1'b0; cur_len = LEN3_C; end
            default: ;
        endcase
    end

    // pcnt_reg holds the Opn cycles already seen; pcnt_next is the count including this cycle.
    assign pcnt_next = (pcnt_reg == '1) ? pcnt_reg : pcnt_reg + 1'b1;
    assign ph_e2 = ph_cur ? (pcnt_next > cur_len) : (pcnt_reg != cur_len);
    assign ph_e3 = ph_cur ? (dout != cur_exp) : (nxt_chk && (dout != nxt_exp));
    assign w_e3  = op1 && (dout != exp1);

    // Any cycle that is not a continuation of the current phase is either the first cycle of
    // a new phase or irrelevant, so the count restarts at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_reg <= '0;
        end else if (ph_cur) begin
            pcnt_reg <= pcnt_next;
        end else begin
            pcnt_reg <= CNT_W'(1);
        end
    end
`else
    assign ph_e2 = 1'b0;
    assign ph_e3 = 1'b0;
    assign w_e3  = 1'b0;
`endif

    // Same-cycle priority: order (4) > length (2) > value (3).
    assign ph_code = ph_e4 ? 3'd4 : ph_e2 ? 3'd2 : ph_e3 ? 3'd3 : 3'd0;
    assign w_code  = w_e4  ? 3'd4 : w_e3  ? 3'd3 : 3'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            start_n_reg  <= 1'b1;
            err_reg      <= 1'b0;
            err_code_reg <= 3'd0;
            din1_reg     <= 3'd0;
            din2_reg     <= 3'd0;
            res1_reg     <= 3'd0;
            res2_reg     <= 3'd0;
            res3_reg     <= 3'd0;
            scnt_reg     <= '0;
            tcnt_reg     <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (req && ready) begin
                        din1_reg     <= req_a;
                        din2_reg     <= req_b;
                        busy_reg     <= 1'b1;
                        start_n_reg  <= 1'b0;
                        err_reg      <= 1'b0;
                        err_code_reg <= 3'd0;
                        scnt_reg     <= CNT_W'(1);
                        tcnt_reg     <= CNT_W'(1);
                        state_reg    <= S_START;
                    end
                end
                S_START, S_WAIT1: begin
                    tcnt_reg <= tcnt_next;
                    if (op1 && !w_e4) begin
                        res1_reg <= dout;
                    end
                    if (w_code != 3'd0) begin
                        start_n_reg  <= 1'b1;
                        err_reg      <= 1'b1;
                        err_code_reg <= w_code;
                        state_reg    <= S_DRAIN;
                    end else if (op1) begin
                        // The PSM may react to the falling edge before the pulse ends.
                        start_n_reg <= 1'b1;
                        state_reg   <= S_PH1;
                    end else if (state_reg == S_START) begin
                        if (scnt_reg >= START_LEN_C) begin
                            start_n_reg <= 1'b1;
                            state_reg   <= S_WAIT1;
                        end else begin
                            scnt_reg <= scnt_reg + 1'b1;
                        end
                    end else if (tcnt_reg >= TIMEOUT_C) begin
                        err_reg      <= 1'b1;
                        err_code_reg <= 3'd1;
                        state_reg    <= S_DRAIN;
                    end
                end
                S_PH1, S_PH2, S_PH3: begin
                    if (!ph_e4) begin
                        case (state_reg)
                            S_PH1:   if (op1) res1_reg <= dout; else res2_reg <= dout;
                            S_PH2:   if (op2) res2_reg <= dout; else res3_reg <= dout;
                            default: if (op3) res3_reg <= dout;
                        endcase
                    end
                    if (ph_code != 3'd0) begin
                        err_reg      <= 1'b1;
                        err_code_reg <= ph_code;
                        state_reg    <= S_DRAIN;
                    end else if (ph_nxt) begin
                        case (state_reg)
                            S_PH1: state_reg <= S_PH2;
                            S_PH2: state_reg <= S_PH3;
                            default: begin
                                done_reg  <= 1'b1;
                                busy_reg  <= 1'b0;
                                state_reg <= S_FIN;
                            end
                        endcase
                    end
                end
                S_DRAIN: begin
                    if (ready) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= S_FIN;
                    end
                end
                S_FIN: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign start_n  = start_n_reg;
    assign err      = err_reg;
    assign err_code = err_code_reg;
    assign din1     = din1_reg;
    assign din2     = din2_reg;
    assign res1     = res1_reg;
    assign res2     = res2_reg;
    assign res3     = res3_reg;

endmodule
